// File: rtl/vga_linebuf_ctrl.sv
// Triple-buffered scanline store: PPU fills one bank while VGA shows another, each line shown twice.
// Optional LINEBUF_REPEAT_EN: on underrun keep showing the previous line instead of blanking.
module vga_linebuf_ctrl #(
  parameter int LINE_W = 256,
  parameter int PIX_W = 6,
  parameter logic [PIX_W-1:0] BLANK_PX = 6'h0F
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_en,
  input  logic                      ppu_pix_we,
  input  logic [$clog2(LINE_W)-1:0] ppu_pix_idx,
  input  logic [PIX_W-1:0]          ppu_pix_data,
  input  logic                      ppu_line_done,
  output logic                      ppu_ready,
  input  logic                      vga_frame_start,
  input  logic                      vga_line_start,
  input  logic [$clog2(LINE_W)-1:0] vga_buf_idx,
  output logic [PIX_W-1:0]          vga_buf_out,
  output logic                      underrun,
  output logic                      overrun,
  output logic [7:0]                ovr_cnt
);

  typedef enum logic [1:0] {B_FREE, B_FILL, B_READY, B_SHOW} bank_st_e;

  bank_st_e         st_q [3];
  bank_st_e         st_d [3];
  logic [1:0]       rq_q [2];
  logic [1:0]       rq_d [2];
  logic [1:0]       rcnt_q, rcnt_d;
  logic             phase_q, phase_d;
  logic             under_q, under_d;
  logic             over_q, over_d;
  logic [7:0]       ovr_cnt_q, ovr_cnt_d;
  logic [PIX_W-1:0] buf_out_q, buf_out_d;

  logic             cur_fill_v, cur_show_v;
  logic [1:0]       cur_fill_id, cur_show_id;
  logic             phase_eff;
  logic             have_fill;

  logic [PIX_W-1:0] mem [3][LINE_W];

  always_comb begin
    cur_fill_v  = 1'b0;
    cur_fill_id = 2'd0;
    cur_show_v  = 1'b0;
    cur_show_id = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (st_q[i] == B_FILL) begin
        cur_fill_v  = 1'b1;
        cur_fill_id = 2'(i);
      end
      if (st_q[i] == B_SHOW) begin
        cur_show_v  = 1'b1;
        cur_show_id = 2'(i);
      end
    end
  end

  // line_done is applied before line_start so a just-completed line can be shown at once.
  always_comb begin
    st_d      = st_q;
    rq_d      = rq_q;
    rcnt_d    = rcnt_q;
    under_d   = 1'b0;
    over_d    = (ppu_pix_we || ppu_line_done) && !cur_fill_v;
    ovr_cnt_d = (over_d && ovr_cnt_q != 8'hFF) ? ovr_cnt_q + 8'd1 : ovr_cnt_q;
    phase_eff = vga_frame_start ? 1'b0 : phase_q;
    phase_d   = vga_line_start ? !phase_eff : phase_eff;
    have_fill = 1'b0;

    if (ppu_line_done && cur_fill_v) begin
      st_d[cur_fill_id] = B_READY;
      rq_d[rcnt_d[0]]   = cur_fill_id;
      rcnt_d            = rcnt_d + 2'd1;
    end

    if (vga_line_start && !phase_eff) begin
      if (rcnt_d != 2'd0) begin
        if (cur_show_v) st_d[cur_show_id] = B_FREE;
        st_d[rq_d[0]] = B_SHOW;
        rq_d[0]       = rq_d[1];
        rcnt_d        = rcnt_d - 2'd1;
      end else begin
        under_d = 1'b1;
`ifndef LINEBUF_REPEAT_EN
        if (cur_show_v) st_d[cur_show_id] = B_FREE;
`endif
      end
    end

    // A new FILL bank is granted only while the READY queue still has room for it.
    for (int i = 0; i < 3; i++) begin
      if (st_d[i] == B_FILL) have_fill = 1'b1;
    end
    if (!have_fill && rcnt_d != 2'd2) begin
      for (int i = 0; i < 3; i++) begin
        if (!have_fill && st_d[i] == B_FREE) begin
          st_d[i]   = B_FILL;
          have_fill = 1'b1;
        end
      end
    end

    buf_out_d = cur_show_v ? mem[cur_show_id][vga_buf_idx] : BLANK_PX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]   <= B_FILL;
      st_q[1]   <= B_FREE;
      st_q[2]   <= B_FREE;
      rq_q[0]   <= 2'd0;
      rq_q[1]   <= 2'd0;
      rcnt_q    <= 2'd0;
      phase_q   <= 1'b0;
      under_q   <= 1'b0;
      over_q    <= 1'b0;
      ovr_cnt_q <= 8'd0;
      buf_out_q <= BLANK_PX;
    end else if (clk_en) begin
      st_q      <= st_d;
      rq_q      <= rq_d;
      rcnt_q    <= rcnt_d;
      phase_q   <= phase_d;
      under_q   <= under_d;
      over_q    <= over_d;
      ovr_cnt_q <= ovr_cnt_d;
      buf_out_q <= buf_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && clk_en && ppu_pix_we && cur_fill_v) begin
      mem[cur_fill_id][ppu_pix_idx] <= ppu_pix_data;
    end
  end

  assign ppu_ready   = cur_fill_v;
  assign vga_buf_out = buf_out_q;
  assign underrun    = under_q;
  assign overrun     = over_q;
  assign ovr_cnt     = ovr_cnt_q;

endmodule

// File: tb/tb_vga_linebuf_ctrl.sv
// Bench for vga_linebuf_ctrl: directed scenarios plus randomized traffic against a bank/queue model.
// Honours LINEBUF_REPEAT_EN the same way as the design.
module tb_vga_linebuf_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic       ppu_pix_we = 1'b0;
  logic [7:0] ppu_pix_idx = 8'd0;
  logic [5:0] ppu_pix_data = 6'd0;
  logic       ppu_line_done = 1'b0;
  logic       ppu_ready;
  logic       vga_frame_start = 1'b0;
  logic       vga_line_start = 1'b0;
  logic [7:0] vga_buf_idx = 8'd0;
  logic [5:0] vga_buf_out;
  logic       underrun;
  logic       overrun;
  logic [7:0] ovr_cnt;

  int checks = 0;
  int failures = 0;

  vga_linebuf_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .ppu_pix_we(ppu_pix_we), .ppu_pix_idx(ppu_pix_idx), .ppu_pix_data(ppu_pix_data),
    .ppu_line_done(ppu_line_done), .ppu_ready(ppu_ready),
    .vga_frame_start(vga_frame_start), .vga_line_start(vga_line_start),
    .vga_buf_idx(vga_buf_idx), .vga_buf_out(vga_buf_out),
    .underrun(underrun), .overrun(overrun), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  // Model: which bank is being filled / shown, completed lines in order, line contents.
  int         m_fill, m_show, m_phase;
  int         m_rq[$];
  logic [5:0] m_mem [3][256];
  logic [5:0] exp_out;
  logic       exp_under, exp_over;
  int         exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bank_busy(input int b);
    if (b == m_fill || b == m_show) return 1'b1;
    foreach (m_rq[k]) if (m_rq[k] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_fill = 0; m_show = -1; m_phase = 0;
    m_rq.delete();
    exp_out = 6'h0F; exp_under = 1'b0; exp_over = 1'b0; exp_cnt = 0;
  endtask

  task automatic model_step();
    logic [5:0] nxt_out;
    int ph;
    if (!clk_en) return;
    nxt_out = (m_show >= 0) ? m_mem[m_show][vga_buf_idx] : 6'h0F;
    if (ppu_pix_we && m_fill >= 0) m_mem[m_fill][ppu_pix_idx] = ppu_pix_data;
    exp_over = (ppu_pix_we || ppu_line_done) && (m_fill < 0);
    if (exp_over && exp_cnt < 255) exp_cnt++;
    if (ppu_line_done && m_fill >= 0) begin
      m_rq.push_back(m_fill);
      m_fill = -1;
    end
    ph = vga_frame_start ? 0 : m_phase;
    exp_under = 1'b0;
    if (vga_line_start) begin
      if (ph == 0) begin
        if (m_rq.size() > 0) m_show = m_rq.pop_front();
        else begin
          exp_under = 1'b1;
`ifndef LINEBUF_REPEAT_EN
          m_show = -1;
`endif
        end
      end
      m_phase = 1 - ph;
    end else m_phase = ph;
    if (m_fill < 0 && m_rq.size() < 2) begin
      for (int b = 0; b < 3; b++) begin
        if (m_fill < 0 && !bank_busy(b)) m_fill = b;
      end
    end
    exp_out = nxt_out;
  endtask

  task automatic compare_all();
    chk("ppu_ready", 32'(ppu_ready), 32'(m_fill >= 0));
    if (!$isunknown(exp_out)) chk("vga_buf_out", 32'(vga_buf_out), 32'(exp_out));
    chk("underrun", 32'(underrun), 32'(exp_under));
    chk("overrun", 32'(overrun), 32'(exp_over));
    chk("ovr_cnt", 32'(ovr_cnt), 32'(exp_cnt));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    clk_en = 1'b1; ppu_pix_we = 1'b0; ppu_line_done = 1'b0;
    vga_frame_start = 1'b0; vga_line_start = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input int idx, input logic [5:0] d);
    ppu_pix_we = 1'b1; ppu_pix_idx = 8'(idx); ppu_pix_data = d;
    tick();
    ppu_pix_we = 1'b0;
  endtask

  task automatic line_done();
    ppu_line_done = 1'b1; tick(); ppu_line_done = 1'b0;
  endtask

  task automatic line_start();
    vga_line_start = 1'b1; tick(); vga_line_start = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < 3; b++)
      for (int p = 0; p < 256; p++) m_mem[b][p] = 6'bx;

    // 1: fill bank0 with idx[5:0], complete it, show it
    do_reset();
    chk("rst_ready", 32'(ppu_ready), 32'd1);
    chk("rst_out", 32'(vga_buf_out), 32'h0F);
    chk("rst_ovr_cnt", 32'(ovr_cnt), 32'd0);
    for (int i = 0; i < 256; i++) wr(i, 6'(i));
    line_done();
    line_start();
    vga_buf_idx = 8'd5;
    tick();
    chk("s1_out_idx5", 32'(vga_buf_out), 32'h05);
    chk("s1_ready", 32'(ppu_ready), 32'd1);

    // 2: second row repeats, third row underruns
    line_start();
    tick();
    chk("s2_repeat", 32'(vga_buf_out), 32'h05);
    line_start();
    chk("s2_underrun", 32'(underrun), 32'd1);
    tick();
`ifdef LINEBUF_REPEAT_EN
    chk("s2_out_after_under", 32'(vga_buf_out), 32'h05);
`else
    chk("s2_out_after_under", 32'(vga_buf_out), 32'h0F);
`endif
    chk("s2_under_clear", 32'(underrun), 32'd0);

    // 3: PPU runs ahead with no VGA reads
    do_reset();
    line_done();
    line_done();
    chk("s3_ready_low", 32'(ppu_ready), 32'd0);
    wr(3, 6'h11);
    chk("s3_overrun", 32'(overrun), 32'd1);
    chk("s3_ovr_cnt", 32'(ovr_cnt), 32'd1);

    // 4: line_done and line_start together with nothing queued
    do_reset();
    wr(9, 6'h2A);
    ppu_line_done = 1'b1; vga_line_start = 1'b1;
    tick();
    ppu_line_done = 1'b0; vga_line_start = 1'b0;
    chk("s4_no_underrun", 32'(underrun), 32'd0);
    vga_buf_idx = 8'd9;
    tick();
    chk("s4_out", 32'(vga_buf_out), 32'h2A);

    // 5: frame_start while in the second row of a pair
    wr(3, 6'h15);
    line_done();
    vga_frame_start = 1'b1; tick(); vga_frame_start = 1'b0;
    line_start();
    chk("s5_no_underrun", 32'(underrun), 32'd0);
    vga_buf_idx = 8'd3;
    tick();
    chk("s5_out", 32'(vga_buf_out), 32'h15);

    // 6: async reset mid-write with clk_en toggling
    for (int i = 0; i < 12; i++) begin
      clk_en = 1'($urandom_range(0, 1));
      ppu_pix_we = 1'b1; ppu_pix_idx = 8'($urandom_range(0, 255));
      ppu_pix_data = 6'($urandom_range(0, 63));
      ppu_line_done = (i == 6);
      vga_line_start = (i == 8);
      tick();
    end
    #2;
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_async_ready", 32'(ppu_ready), 32'd1);
    chk("s6_async_out", 32'(vga_buf_out), 32'h0F);
    chk("s6_async_ovr_cnt", 32'(ovr_cnt), 32'd0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    line_start();
    chk("s6_underrun", 32'(underrun), 32'd1);
    tick();
    chk("s6_blank", 32'(vga_buf_out), 32'h0F);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      clk_en          = ($urandom_range(0, 3) != 0);
      ppu_pix_we      = ($urandom_range(0, 1) == 1);
      ppu_pix_idx     = 8'($urandom_range(0, 255));
      ppu_pix_data    = 6'($urandom_range(0, 63));
      ppu_line_done   = ($urandom_range(0, 39) == 0);
      vga_line_start  = ($urandom_range(0, 29) == 0);
      vga_frame_start = ($urandom_range(0, 199) == 0);
      vga_buf_idx     = 8'($urandom_range(0, 255));
      tick();
    end
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
